// File: rtl/sim_scheduler_pkg.sv
// Shared types and default sizes for the board-update scheduler.
// The engine command opcodes are also used by the board engine itself.
package sim_scheduler_pkg;

    localparam int LOG_MAX_SPEED  = 3;
    localparam int MAX_SPEED      = 2**LOG_MAX_SPEED - 1;
    localparam int LOG_BOARD_SIZE = 6;
    localparam int LOG_NUM_SEED   = 2;
    localparam int GEN_WIDTH      = 16;

    typedef enum logic [1:0] {
        NOP    = 2'd0,
        SEED   = 2'd1,
        TOGGLE = 2'd2,
        STEP   = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2
    } sched_state_t;

    // Seed loads outrank user toggles, which outrank timed steps.
    function automatic cmd_op_t pick_op(input logic seed_p, input logic toggle_p,
                                        input logic step_p);
        if (seed_p) begin
            return SEED;
        end
        if (toggle_p) begin
            return TOGGLE;
        end
        if (step_p) begin
            return STEP;
        end
        return NOP;
    endfunction

endpackage

// File: rtl/sim_scheduler_if.sv
// Command channel between the scheduler (master) and the board engine (slave).
// Signal names follow the scheduler's point of view.
interface sim_scheduler_if #(
    parameter int LOG_BOARD_SIZE = sim_scheduler_pkg::LOG_BOARD_SIZE,
    parameter int LOG_NUM_SEED   = sim_scheduler_pkg::LOG_NUM_SEED
);

    logic                       cmd_valid_out;
    sim_scheduler_pkg::cmd_op_t cmd_op_out;
    logic [LOG_BOARD_SIZE-1:0]  cmd_x_out;
    logic [LOG_BOARD_SIZE-1:0]  cmd_y_out;
    logic [LOG_NUM_SEED-1:0]    cmd_seed_out;
    logic                       cmd_ready_in;
    logic                       done_in;

    modport master (
        output cmd_valid_out,
        output cmd_op_out,
        output cmd_x_out,
        output cmd_y_out,
        output cmd_seed_out,
        input  cmd_ready_in,
        input  done_in
    );

    modport slave (
        input  cmd_valid_out,
        input  cmd_op_out,
        input  cmd_x_out,
        input  cmd_y_out,
        input  cmd_seed_out,
        output cmd_ready_in,
        output done_in
    );

endinterface

// File: rtl/sim_scheduler_step_timer.sv
// Frame divider: counts video frames and fires a one-cycle tick every
// (MAX_SPEED - speed + 1) frames; speed 0 freezes the count.
module step_timer
    import sim_scheduler_pkg::*;
#(
    parameter int SPEED_W = LOG_MAX_SPEED
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               frame_in,
    input  logic [SPEED_W-1:0] speed_in,
    input  logic               clear_in,
    output logic               tick_out
);

    localparam logic [SPEED_W:0] MAX_PERIOD = (SPEED_W+1)'(2**SPEED_W - 1);
    localparam logic [SPEED_W:0] ONE        = (SPEED_W+1)'(1);

    logic [SPEED_W-1:0] fcnt;
    logic [SPEED_W:0]   period;
    logic [SPEED_W:0]   fcnt_next;
    logic               running;
    logic               expire;

    // The >= compare lets a freshly shortened period fire on the very next frame.
    always_comb begin
        period    = MAX_PERIOD - {1'b0, speed_in} + ONE;
        fcnt_next = {1'b0, fcnt} + ONE;
        running   = (speed_in != '0);
        expire    = frame_in && running && (fcnt_next >= period);
        tick_out  = expire && !clear_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            fcnt <= '0;
        end else if (clear_in) begin
            fcnt <= '0;
        end else if (frame_in && running) begin
            if (expire) begin
                fcnt <= '0;
            end else begin
                fcnt <= fcnt_next[SPEED_W-1:0];
            end
        end
    end

endmodule

// File: rtl/sim_scheduler.sv
// Serialises UI events into SEED / TOGGLE / STEP commands for the board engine,
// one at a time, and counts generations since the last seed load.
module sim_scheduler #(
    parameter int LOG_MAX_SPEED  = sim_scheduler_pkg::LOG_MAX_SPEED,
    parameter int LOG_BOARD_SIZE = sim_scheduler_pkg::LOG_BOARD_SIZE,
    parameter int LOG_NUM_SEED   = sim_scheduler_pkg::LOG_NUM_SEED,
    parameter int GEN_WIDTH      = sim_scheduler_pkg::GEN_WIDTH
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      frame_in,
    input  logic [LOG_MAX_SPEED-1:0]  speed_in,
    input  logic                      click_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
    input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
    input  logic [LOG_NUM_SEED-1:0]   seed_idx_in,
    output logic                      busy_out,
    output logic [GEN_WIDTH-1:0]      gen_count_out,
    sim_scheduler_if.master           cmd_bus
);

    import sim_scheduler_pkg::*;

    sched_state_t state;
    sched_state_t state_next;

    logic seed_pend;
    logic toggle_pend;
    logic step_pend;

    logic [LOG_NUM_SEED-1:0]   last_seed;
    logic [LOG_BOARD_SIZE-1:0] tog_x;
    logic [LOG_BOARD_SIZE-1:0] tog_y;

    cmd_op_t                   pick;
    cmd_op_t                   cur_op;
    logic [LOG_BOARD_SIZE-1:0] cur_x;
    logic [LOG_BOARD_SIZE-1:0] cur_y;
    logic [LOG_NUM_SEED-1:0]   cur_seed;

    logic capture;
    logic accept;
    logic finish;
    logic seed_done;
    logic step_tick;

    logic [GEN_WIDTH-1:0] gen_count;

    // A finished seed load restarts the frame divider so stepping is phase-aligned to the new board.
    step_timer #(
        .SPEED_W (LOG_MAX_SPEED)
    ) u_step_timer (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .frame_in (frame_in),
        .speed_in (speed_in),
        .clear_in (seed_done),
        .tick_out (step_tick)
    );

    assign pick      = pick_op(seed_pend, toggle_pend, step_pend);
    assign seed_done = finish && (cur_op == SEED);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (pick != NOP) begin
                    state_next = ISSUE;
                    capture    = 1'b1;
                end
            end
            ISSUE: begin
                if (cmd_bus.cmd_ready_in) begin
                    state_next = BUSY;
                    accept     = 1'b1;
                end
            end
            BUSY: begin
                if (cmd_bus.done_in) begin
                    state_next = IDLE;
                    finish     = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The command is frozen at the IDLE->ISSUE transition; later events only raise flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cur_op   <= NOP;
            cur_x    <= '0;
            cur_y    <= '0;
            cur_seed <= '0;
        end else if (capture) begin
            cur_op   <= pick;
            cur_x    <= tog_x;
            cur_y    <= tog_y;
            cur_seed <= last_seed;
        end
    end

    // A fresh event wins over the clear on accept so a late seed change is never lost.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            seed_pend   <= 1'b1;
            toggle_pend <= 1'b0;
            step_pend   <= 1'b0;
            last_seed   <= '0;
            tog_x       <= '0;
            tog_y       <= '0;
        end else begin
            if (seed_idx_in != last_seed) begin
                seed_pend <= 1'b1;
                last_seed <= seed_idx_in;
            end else if (accept && (cur_op == SEED)) begin
                seed_pend <= 1'b0;
            end

            if (click_in && !toggle_pend) begin
                toggle_pend <= 1'b1;
                tog_x       <= cursor_x_in;
                tog_y       <= cursor_y_in;
            end else if (accept && (cur_op == TOGGLE)) begin
                toggle_pend <= 1'b0;
            end

            if (seed_done) begin
                step_pend <= 1'b0;
            end else if (step_tick) begin
                step_pend <= 1'b1;
            end else if (accept && (cur_op == STEP)) begin
                step_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            gen_count <= '0;
        end else if (finish) begin
            if (cur_op == STEP) begin
                gen_count <= gen_count + 1'b1;
            end else if (cur_op == SEED) begin
                gen_count <= '0;
            end
        end
    end

    assign cmd_bus.cmd_valid_out = (state == ISSUE);
    assign cmd_bus.cmd_op_out    = (state == ISSUE) ? cur_op : NOP;
    assign cmd_bus.cmd_x_out     = cur_x;
    assign cmd_bus.cmd_y_out     = cur_y;
    assign cmd_bus.cmd_seed_out  = cur_seed;
    assign busy_out              = (state != IDLE);
    assign gen_count_out         = gen_count;

endmodule
